// File: rtl/axis_nway_alu_pkg.sv
// Shared definitions for the N-way AXI-Stream join ALU: op encodings and
// the width rule for the carry-preserving ADD accumulator.
package axis_nway_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_MAX = 2'b01,
        OP_MIN = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    // Summing num_ch words of data_w bits never needs more than clog2(num_ch) extra bits.
    function automatic int add_sum_width(input int data_w, input int num_ch);
        return data_w + $clog2(num_ch);
    endfunction

endpackage

// File: rtl/axis_result_fifo.sv
// Result buffer: power-of-two circular FIFO, valid/ready on both sides,
// head word driven straight from storage registers.
module axis_result_fifo #(
    parameter int W          = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_full
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign o_ready = ~o_full;
    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];

    // A full FIFO refuses the push even when the head is popped in the same cycle.
    assign w_push = i_valid & ~o_full;
    assign w_pop  = o_valid & i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/axis_nway_alu.sv
// N-way AXI-Stream join ALU: one beat from every slave channel is reduced
// (ADD/MAX/MIN/XOR) into a single buffered master result.
module axis_nway_alu
    import axis_nway_alu_pkg::*;
#(
    parameter int TDATA_WIDTH_BYTES = 4,
    parameter int NUM_CH            = 2,
    parameter int FIFO_DEPTH        = 4,
    parameter bit SATURATE          = 1'b0
) (
    input  logic                                 aclk,
    input  logic                                 resetn,
    input  logic [1:0]                           op,
    input  logic [NUM_CH-1:0]                    s_axis_tvalid,
    output logic [NUM_CH-1:0]                    s_axis_tready,
    input  logic [NUM_CH*8*TDATA_WIDTH_BYTES-1:0] s_axis_tdata,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic [8*TDATA_WIDTH_BYTES-1:0]       m_axis_tdata,
    output logic                                 overflow,
    input  logic                                 clr_overflow,
    output logic [31:0]                          xfer_count
);
    localparam int W     = 8 * TDATA_WIDTH_BYTES;
    localparam int SUM_W = add_sum_width(W, NUM_CH);

    logic             r_active;
    logic             r_overflow;
    logic [31:0]      r_xfer_count;
    logic             w_all_valid;
    logic             w_accept;
    logic             w_fifo_ready;
    logic             w_fifo_full;
    logic             w_carry;
    logic             w_is_add;
    logic [SUM_W-1:0] w_sum;
    logic [W-1:0]     w_chan;
    logic [W-1:0]     w_max;
    logic [W-1:0]     w_min;
    logic [W-1:0]     w_xor;
    logic [W-1:0]     w_result;

    // Handshake: a beat moves on a channel when valid & ready are both high at
    // the rising edge; all slave readies are one shared join signal that never
    // looks at m_axis_tready, and valid/data are held stable until accepted.
    assign w_all_valid   = &s_axis_tvalid;
    assign w_accept      = w_all_valid & w_fifo_ready & ~w_fifo_full & r_active;
    assign s_axis_tready = {NUM_CH{w_accept}};

    // Holds off acceptance until the first edge after reset release.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
        end
    end

    always_comb begin
        w_sum  = '0;
        w_max  = '0;
        w_min  = '1;
        w_xor  = '0;
        w_chan = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_chan = s_axis_tdata[k*W +: W];
            w_sum  = w_sum + SUM_W'(w_chan);
            if (w_chan > w_max) w_max = w_chan;
            if (w_chan < w_min) w_min = w_chan;
            w_xor  = w_xor ^ w_chan;
        end
    end

    assign w_carry  = |w_sum[SUM_W-1:W];
    assign w_is_add = (op == OP_ADD);

    always_comb begin
        w_result = '0;
        case (op_e'(op))
            OP_ADD:  w_result = (SATURATE && w_carry) ? '1 : w_sum[W-1:0];
            OP_MAX:  w_result = w_max;
            OP_MIN:  w_result = w_min;
            OP_XOR:  w_result = w_xor;
            default: w_result = '0;
        endcase
    end

    axis_result_fifo #(
        .W          (W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (aclk),
        .rst_n   (resetn),
        .i_valid (w_accept),
        .o_ready (w_fifo_ready),
        .i_data  (w_result),
        .o_valid (m_axis_tvalid),
        .i_ready (m_axis_tready),
        .o_data  (m_axis_tdata),
        .o_full  (w_fifo_full)
    );

    // A new carry outranks a clear arriving in the same cycle.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_overflow <= 1'b0;
        end else if (w_accept && w_is_add && w_carry) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_xfer_count <= '0;
        end else if (m_axis_tvalid && m_axis_tready) begin
            r_xfer_count <= r_xfer_count + 32'd1;
        end
    end

    assign overflow   = r_overflow;
    assign xfer_count = r_xfer_count;

endmodule

// File: tb/tb_axis_nway_alu.sv
// Directed bench for axis_nway_alu: a 2-channel wrapping instance and a
// 3-channel saturating instance, each with an in-order result scoreboard.
module tb_axis_nway_alu;
    import axis_nway_alu_pkg::*;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic aclk   = 1'b0;
    logic resetn = 1'b0;
    always #5 aclk = ~aclk;

    // ---------------- DUT A: NUM_CH=2, wrapping ADD ----------------
    logic [1:0]     op_a   = 2'b00;
    logic [1:0]     vld_a  = 2'b00;
    logic [1:0]     rdy_a;
    logic [2*W-1:0] data_a = '0;
    logic           mv_a;
    logic           mr_a   = 1'b1;
    logic [W-1:0]   md_a;
    logic           ovf_a;
    logic           clr_a  = 1'b0;
    logic [31:0]    xc_a;

    axis_nway_alu #(
        .TDATA_WIDTH_BYTES (4),
        .NUM_CH            (2),
        .FIFO_DEPTH        (4),
        .SATURATE          (1'b0)
    ) u_dut_a (
        .aclk          (aclk),
        .resetn        (resetn),
        .op            (op_a),
        .s_axis_tvalid (vld_a),
        .s_axis_tready (rdy_a),
        .s_axis_tdata  (data_a),
        .m_axis_tvalid (mv_a),
        .m_axis_tready (mr_a),
        .m_axis_tdata  (md_a),
        .overflow      (ovf_a),
        .clr_overflow  (clr_a),
        .xfer_count    (xc_a)
    );

    // ---------------- DUT B: NUM_CH=3, saturating ADD ----------------
    logic [1:0]     op_b   = 2'b00;
    logic [2:0]     vld_b  = 3'b000;
    logic [2:0]     rdy_b;
    logic [3*W-1:0] data_b = '0;
    logic           mv_b;
    logic           mr_b   = 1'b1;
    logic [W-1:0]   md_b;
    logic           ovf_b;
    logic           clr_b  = 1'b0;
    logic [31:0]    xc_b;

    axis_nway_alu #(
        .TDATA_WIDTH_BYTES (4),
        .NUM_CH            (3),
        .FIFO_DEPTH        (4),
        .SATURATE          (1'b1)
    ) u_dut_b (
        .aclk          (aclk),
        .resetn        (resetn),
        .op            (op_b),
        .s_axis_tvalid (vld_b),
        .s_axis_tready (rdy_b),
        .s_axis_tdata  (data_b),
        .m_axis_tvalid (mv_b),
        .m_axis_tready (mr_b),
        .m_axis_tdata  (md_b),
        .overflow      (ovf_b),
        .clr_overflow  (clr_b),
        .xfer_count    (xc_b)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q_a[$];
    logic [W-1:0] exp_q_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge aclk) begin
        if (resetn && mv_a && mr_a) begin
            if (exp_q_a.size() == 0) check("a_unexpected_beat", 32'(mv_a), 32'd0);
            else check("a_order", md_a, exp_q_a.pop_front());
        end
        if (resetn && mv_b && mr_b) begin
            if (exp_q_b.size() == 0) check("b_unexpected_beat", 32'(mv_b), 32'd0);
            else check("b_order", md_b, exp_q_b.pop_front());
        end
    end

    // ---------------- drivers ----------------
    task automatic join_a(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic clr);
        @(posedge aclk); #1;
        op_a   = op;
        data_a = {b, a};
        vld_a  = 2'b11;
        clr_a  = clr;
        @(negedge aclk);
        check("a_join_ready", 32'(rdy_a), 32'd3);
        @(posedge aclk); #1;
        vld_a = 2'b00;
        clr_a = 1'b0;
    endtask

    task automatic join_b(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c);
        @(posedge aclk); #1;
        op_b   = op;
        data_b = {c, b, a};
        vld_b  = 3'b111;
        @(negedge aclk);
        check("b_join_ready", 32'(rdy_b), 32'd7);
        @(posedge aclk); #1;
        vld_b = 3'b000;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        clr;
        logic [31:0] exp_d;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{OP_ADD, 32'd3,          32'd5,          1'b0, 32'd8,          1'b0};
        vecs[1] = '{OP_MAX, 32'h10,         32'h7,          1'b0, 32'h10,         1'b0};
        vecs[2] = '{OP_MIN, 32'h10,         32'h7,          1'b0, 32'h7,          1'b0};
        vecs[3] = '{OP_XOR, 32'hF0F0F0F0,   32'h0FF00FF0,   1'b0, 32'hFF00FF00,   1'b0};
        vecs[4] = '{OP_ADD, 32'hFFFFFFFF,   32'd2,          1'b0, 32'h00000001,   1'b1};
        vecs[5] = '{OP_MAX, 32'hFFFFFFFF,   32'd0,          1'b0, 32'hFFFFFFFF,   1'b1};
        vecs[6] = '{OP_ADD, 32'h80000000,   32'h80000000,   1'b1, 32'h00000000,   1'b1};
        vecs[7] = '{OP_MIN, 32'd0,          32'd5,          1'b1, 32'd0,          1'b0};
        vecs[8] = '{OP_ADD, 32'h12345678,   32'h11111111,   1'b0, 32'h23456789,   1'b0};
        vecs[9] = '{OP_MAX, 32'd5,          32'hFFFFFFFE,   1'b0, 32'hFFFFFFFE,   1'b0};

        // Reset with valids already asserted: nothing may be ready or valid.
        vld_a  = 2'b11;
        data_a = {32'd9, 32'd9};
        vld_b  = 3'b111;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_a_ready", 32'(rdy_a), 32'd0);
        check("rst_a_valid", 32'(mv_a), 32'd0);
        check("rst_a_data", md_a, 32'd0);
        check("rst_a_ovf", 32'(ovf_a), 32'd0);
        check("rst_a_xfer", xc_a, 32'd0);
        check("rst_b_ready", 32'(rdy_b), 32'd0);
        check("rst_b_valid", 32'(mv_b), 32'd0);
        @(posedge aclk); #1;
        resetn = 1'b1;
        vld_a  = 2'b00;
        vld_b  = 3'b000;
        repeat (2) @(posedge aclk);

        // Table: one join per row, downstream always ready.
        for (int i = 0; i < 10; i++) begin
            exp_q_a.push_back(vecs[i].exp_d);
            join_a(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].clr);
            @(negedge aclk);
            check("a_vec_valid", 32'(mv_a), 32'd1);
            check("a_vec_data", md_a, vecs[i].exp_d);
            check("a_vec_ovf", 32'(ovf_a), 32'(vecs[i].exp_ovf));
            check("a_vec_xfer", xc_a, 32'(i));
        end
        @(posedge aclk);
        @(negedge aclk);
        check("a_table_xfer", xc_a, 32'd10);

        // Only channel 0 valid: no join, no output.
        @(posedge aclk); #1;
        op_a   = OP_ADD;
        data_a = {32'd2, 32'd1};
        vld_a  = 2'b01;
        repeat (10) begin
            @(negedge aclk);
            check("a_partial_ready", 32'(rdy_a), 32'd0);
            check("a_partial_valid", 32'(mv_a), 32'd0);
        end
        @(posedge aclk); #1;
        exp_q_a.push_back(32'd3);
        vld_a = 2'b11;
        @(negedge aclk);
        check("a_partial_join_ready", 32'(rdy_a), 32'd3);
        @(posedge aclk); #1;
        vld_a = 2'b00;
        @(negedge aclk);
        check("a_partial_join_data", md_a, 32'd3);
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check("a_single_join_valid", 32'(mv_a), 32'd0);
        check("a_single_join_xfer", xc_a, 32'd11);

        // Fill the 4-deep FIFO with downstream stalled, then release.
        @(posedge aclk); #1;
        mr_a = 1'b0;
        op_a = OP_ADD;
        for (int k = 0; k < 4; k++) begin
            data_a = {32'h100, 32'(k)};
            vld_a  = 2'b11;
            exp_q_a.push_back(32'h100 + 32'(k));
            @(negedge aclk);
            check("a_fill_ready", 32'(rdy_a), 32'd3);
            @(posedge aclk); #1;
        end
        data_a = {32'h100, 32'd4};
        exp_q_a.push_back(32'h104);
        repeat (2) begin
            @(negedge aclk);
            check("a_full_ready", 32'(rdy_a), 32'd0);
            check("a_full_valid", 32'(mv_a), 32'd1);
            check("a_full_head_stable", md_a, 32'h100);
            @(posedge aclk); #1;
        end
        mr_a = 1'b1;
        @(negedge aclk);
        check("a_full_pop_no_push", 32'(rdy_a), 32'd0);
        @(posedge aclk); #1;
        @(negedge aclk);
        check("a_after_pop_ready", 32'(rdy_a), 32'd3);
        @(posedge aclk); #1;
        data_a = {32'h100, 32'd5};
        exp_q_a.push_back(32'h105);
        @(negedge aclk);
        check("a_push_pop_ready", 32'(rdy_a), 32'd3);
        @(posedge aclk); #1;
        vld_a = 2'b00;
        repeat (4) @(posedge aclk);
        @(negedge aclk);
        check("a_full_drained", 32'(exp_q_a.size()), 32'd0);
        check("a_full_idle", 32'(mv_a), 32'd0);
        check("a_full_xfer", xc_a, 32'd17);

        // Reset with three results buffered and overflow set.
        @(posedge aclk); #1;
        mr_a = 1'b0;
        join_a(OP_XOR, 32'd1, 32'hF0, 1'b0);
        join_a(OP_ADD, 32'hFFFFFFFF, 32'd1, 1'b0);
        join_a(OP_XOR, 32'd3, 32'hF0, 1'b0);
        @(negedge aclk);
        check("a_pre_rst_ovf", 32'(ovf_a), 32'd1);
        check("a_pre_rst_head", md_a, 32'hF1);
        @(posedge aclk); #1;
        vld_a  = 2'b11;
        resetn = 1'b0;
        #1;
        check("a_midrst_valid", 32'(mv_a), 32'd0);
        check("a_midrst_data", md_a, 32'd0);
        check("a_midrst_xfer", xc_a, 32'd0);
        check("a_midrst_ovf", 32'(ovf_a), 32'd0);
        check("a_midrst_ready", 32'(rdy_a), 32'd0);
        exp_q_a.delete();
        repeat (2) @(posedge aclk);
        #1;
        resetn = 1'b1;
        vld_a  = 2'b00;
        mr_a   = 1'b1;
        repeat (5) begin
            @(negedge aclk);
            check("a_no_stale", 32'(mv_a), 32'd0);
        end
        exp_q_a.push_back(32'd8);
        join_a(OP_ADD, 32'd4, 32'd4, 1'b0);
        @(negedge aclk);
        check("a_post_rst_data", md_a, 32'd8);
        @(posedge aclk);
        @(negedge aclk);
        check("a_post_rst_xfer", xc_a, 32'd1);

        // DUT B: MAX then MIN buffered; op changes afterwards must not matter.
        @(posedge aclk); #1;
        mr_b = 1'b0;
        exp_q_b.push_back(32'h20);
        join_b(OP_MAX, 32'd7, 32'h20, 32'd4);
        exp_q_b.push_back(32'd4);
        join_b(OP_MIN, 32'd7, 32'h20, 32'd4);
        op_b = OP_XOR;
        @(negedge aclk);
        check("b_buffered_head", md_b, 32'h20);
        @(posedge aclk); #1;
        mr_b = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("b_order_drained", 32'(exp_q_b.size()), 32'd0);
        check("b_order_xfer", xc_b, 32'd2);

        // Saturating ADD, clear, then non-carry ops.
        exp_q_b.push_back(32'hFFFFFFFF);
        join_b(OP_ADD, 32'hFFFFFFFF, 32'd2, 32'd0);
        @(negedge aclk);
        check("b_sat_data", md_b, 32'hFFFFFFFF);
        check("b_sat_ovf", 32'(ovf_b), 32'd1);
        @(posedge aclk); #1;
        clr_b = 1'b1;
        @(posedge aclk); #1;
        clr_b = 1'b0;
        @(negedge aclk);
        check("b_clr_ovf", 32'(ovf_b), 32'd0);
        exp_q_b.push_back(32'd6);
        join_b(OP_ADD, 32'd1, 32'd2, 32'd3);
        @(negedge aclk);
        check("b_add3_data", md_b, 32'd6);
        check("b_add3_ovf", 32'(ovf_b), 32'd0);
        exp_q_b.push_back(32'd7);
        join_b(OP_XOR, 32'd1, 32'd2, 32'd4);
        @(negedge aclk);
        check("b_xor3_data", md_b, 32'd7);
        exp_q_b.push_back(32'hFFFFFFFF);
        join_b(OP_ADD, 32'h80000000, 32'h80000000, 32'h80000000);
        @(negedge aclk);
        check("b_sat3_data", md_b, 32'hFFFFFFFF);
        check("b_sat3_ovf", 32'(ovf_b), 32'd1);
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("b_final_drained", 32'(exp_q_b.size()), 32'd0);
        check("b_final_xfer", xc_b, 32'd6);

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axis_nway_alu.md
AXIS_NWAY_ALU -- requirements
Module: axis_nway_alu

Interface
REQ-001 SHALL have parameter TDATA_WIDTH_BYTES, default 4: byte width of every data bus (W = 8*TDATA_WIDTH_BYTES).
REQ-002 SHALL have parameter NUM_CH, default 2: number of slave input streams, legal 2..8.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: output result buffer depth, power of two, at least 2.
REQ-004 SHALL have parameter SATURATE, default 0: 1 = ADD clamps at all-ones, 0 = ADD wraps modulo 2^W.
REQ-005 SHALL have port aclk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-007 SHALL have port op  input  2  operation: 00 ADD, 01 MAX, 10 MIN, 11 XOR (unsigned).
REQ-008 SHALL have port s_axis_tvalid  input  NUM_CH  per-channel valid.
REQ-009 SHALL have port s_axis_tready  output  NUM_CH  per-channel ready.
REQ-010 SHALL have port s_axis_tdata  input  NUM_CH*W  channel k at bits [k*W +: W].
REQ-011 SHALL have port m_axis_tvalid  output  1  result valid.
REQ-012 SHALL have port m_axis_tready  input  1  downstream ready.
REQ-013 SHALL have port m_axis_tdata  output  W  result data.
REQ-014 SHALL have port overflow  output  1  sticky ADD-carry flag.
REQ-015 SHALL have port clr_overflow  input  1  synchronous clear of overflow.
REQ-016 SHALL have port xfer_count  output  32  count of completed output handshakes.

Function
REQ-017 Join: SHALL accept one beat from every channel in the same cycle, only when all s_axis_tvalid bits are high and the FIFO is not full.
REQ-018 All s_axis_tready bits SHALL be identical and equal (&s_axis_tvalid) & !full; no channel is ever consumed alone.
REQ-019 s_axis_tready SHALL NOT depend on m_axis_tready; at full, no push even if a pop occurs the same cycle.
REQ-020 op SHALL be sampled in the accept cycle; later op changes do not alter already-buffered results.
REQ-021 ADD: W-bit sum of all channels; carry out of W bits is overflow; SATURATE=1 outputs all-ones on overflow, SATURATE=0 outputs the wrapped sum.
REQ-022 MAX/MIN/XOR: unsigned reduction across all NUM_CH channels; never sets overflow.
REQ-023 Result SHALL be written into the FIFO at the accept edge; m_axis_tvalid rises the cycle after acceptance when the FIFO was empty (latency 1).
REQ-024 m_axis_tdata/m_axis_tvalid SHALL be driven from FIFO head registers and stay stable while tvalid=1 and tready=0.
REQ-025 Simultaneous push and pop when not full and not empty: occupancy unchanged, order preserved.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter spans 0..FIFO_DEPTH.
REQ-027 overflow SHALL set on any accepted ADD with carry, clear on clr_overflow; simultaneous set and clear: set wins.
REQ-028 xfer_count SHALL increment on each m_axis_tvalid & m_axis_tready cycle, wrapping 0xFFFFFFFF to 0.

Reset
REQ-029 resetn low SHALL immediately force s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, overflow=0, xfer_count=0, FIFO empty.
REQ-030 Reset mid-operation SHALL discard all buffered results; first acceptance possible one cycle after resetn deasserts.

Structure
REQ-031 Op encodings (typedef op_e) and the ADD-carry width rule (W + clog2(NUM_CH)) SHALL live in package axis_nway_alu_pkg.
REQ-032 Output buffer SHALL be a sub-module axis_result_fifo (W, FIFO_DEPTH parameters, valid/ready both sides, full flag).

Verification
REQ-033 NUM_CH=2, ADD, a=3, b=5 both valid at cycle 0, tready=1 -> m_axis_tdata=8 at cycle 1, overflow=0, xfer_count=1.
REQ-034 NUM_CH=3, MAX then MIN, inputs 7/0x20/4 -> results 0x20 then 4 in order.
REQ-035 Only channel 0 valid for 10 cycles -> all s_axis_tready=0, no output; channel 1 valid -> single join.
REQ-036 FIFO_DEPTH=4, m_axis_tready=0, 6 joins offered -> exactly 4 accepted, s_axis_tready=0 while full; release -> 4 results in order, then remaining 2.
REQ-037 ADD 0xFFFFFFFF+2: SATURATE=0 -> 0x00000001, overflow=1; SATURATE=1 -> 0xFFFFFFFF, overflow=1; clr_overflow with no carry -> overflow=0.
REQ-038 resetn pulsed low with 3 results buffered -> m_axis_tvalid=0 immediately, xfer_count=0, no stale result after release.
